key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N_CH, 4, number of independent key channels (>=1).
- LOCK_CYCLES, 200, lockout length in clk_fast cycles after each accepted change (>=1).
- LONG_CYCLES, 1000, held-high cycles that qualify a press as long (< 2^DUR_W).
- DUR_W, 16, width of each press-duration value.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_fast, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, reset; synchronous, active-low.
- key_in, in, N_CH, raw asynchronous key levels.
- key_out, out, N_CH, debounced levels.
- rise_o, out, N_CH, one-cycle pulse on key_out 0->1.
- fall_o, out, N_CH, one-cycle pulse on key_out 1->0.
- long_o, out, N_CH, one-cycle pulse when the current press reaches LONG_CYCLES.
- dur_o, out, N_CH*DUR_W, last completed press length; channel i occupies bits [i*DUR_W +: DUR_W].
- dur_valid_o, out, N_CH, one-cycle pulse when dur_o[i] is updated.

Function
REQ-003 Channels SHALL be fully independent; no cross-channel state.
REQ-004 Each key_in bit SHALL pass through a 2-flop synchroniser before any use.
REQ-005 Per-channel FSM SHALL have states IDLE and LOCK.
REQ-006 IDLE: when the synchronised level differs from key_out, key_out SHALL take that level, the lock counter SHALL clear to 0, and the FSM SHALL enter LOCK.
REQ-007 LOCK: the counter SHALL increment each cycle, and input changes SHALL be ignored; at count LOCK_CYCLES-1 the FSM SHALL return to IDLE.
REQ-008 Consecutive key_out changes on one channel SHALL be at least LOCK_CYCLES cycles apart; input latency SHALL be exactly 3 rising edges from a key_in change to the key_out change, when in IDLE.
REQ-009 If the input differs from key_out when LOCK ends, the change SHALL be accepted in the first IDLE cycle.
REQ-010 rise_o/fall_o SHALL be asserted in the same cycle that key_out shows the new level.
REQ-011 The press counter SHALL load 1 in the rise cycle and increment each further cycle key_out is high, saturating at 2^DUR_W-1.
REQ-012 long_o SHALL pulse in the cycle the counter equals LONG_CYCLES, at most once per press; it SHALL NOT pulse on saturation.
REQ-013 On fall, dur_o[i] SHALL latch the counter value (cycles key_out was high), and dur_valid_o[i] SHALL pulse in the fall cycle; dur_o[i] SHALL otherwise hold.
REQ-014 All outputs SHALL be registered.

Reset
REQ-015 While rst=0 at a clk_fast edge, the block SHALL clear the synchronisers, counters, key_out, all pulses and dur_o to 0, and set every FSM to IDLE.
REQ-016 Reset mid-press SHALL produce no fall_o or dur_valid_o.
REQ-017 A key held high through reset release SHALL produce rise_o 3 edges after release.

Structure
REQ-018 Parameter defaults and the IDLE/LOCK state encodings SHALL live in a shared include file.
REQ-019 Per-channel logic SHALL be a sub-module key_conditioner_ch instantiated N_CH times by generate.

Verification (bench params N_CH=2, LOCK_CYCLES=8, LONG_CYCLES=20, DUR_W=8)
REQ-020 Clean press: ch0 rises at edge 10 -> key_out[0]=1 and rise_o[0] pulse at edge 13; ch1 stays 0.
REQ-021 Bounce: ch0 toggles every cycle for 6 cycles after a rise, then settles 1 -> a single rise_o and no fall_o.
REQ-022 Held press of 30 cycles -> long_o pulse exactly 20 cycles after rise_o; on release, fall_o together with dur_valid_o and dur_o[0]=30.
REQ-023 Saturation: press held 300 cycles -> dur_o[0]=255 and only one long_o.
REQ-024 Change during LOCK: release 3 cycles after rise -> fall_o occurs exactly 8 cycles after rise_o.
REQ-025 Reset mid-press: rst=0 for 1 cycle while key_out=1 -> all outputs 0, no fall_o or dur_valid_o, and rise_o returns 3 edges after release if the key is still held.

Source files
------------

// File: rtl/key_conditioner_pkg.sv
// key_conditioner_pkg: shared parameter defaults and per-channel FSM state encoding
package key_conditioner_pkg;
    localparam int N_CH_DEF        = 4;
    localparam int LOCK_CYCLES_DEF = 200;
    localparam int LONG_CYCLES_DEF = 1000;
    localparam int DUR_W_DEF       = 16;
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;
endpackage

// File: rtl/key_conditioner_ch.sv
// key_conditioner_ch: one key channel with synchroniser, lockout debounce, edge pulses and press timing
module key_conditioner_ch
    import key_conditioner_pkg::*;
#(
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF,
    parameter int DUR_W       = DUR_W_DEF
) (
    input  logic             clk_fast,
    input  logic             rst,
    input  logic             i_key,
    output logic             o_key,
    output logic             o_rise,
    output logic             o_fall,
    output logic             o_long,
    output logic [DUR_W-1:0] o_dur,
    output logic             o_dur_valid
);
    localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [DUR_W-1:0] DUR_MAX = '1;
    logic [1:0]       r_sync;
    state_t           r_state, w_state;
    logic [LCW-1:0]   r_cnt, w_cnt;
    logic             r_key, w_key, w_rise, w_fall;
    logic             r_rise, r_fall, r_long, r_long_done, r_dur_v;
    logic [DUR_W-1:0] r_press, r_dur;
    logic             w_at_long;

    // two-flop synchroniser ahead of any use of the raw key level
    always_ff @(posedge clk_fast) begin
        r_sync <= !rst ? 2'b00 : {r_sync[0], i_key};
    end

    // accept a level change while idle, then count out the lockout ignoring the input
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_key   = r_key;
        if (r_state == IDLE) begin
            if (r_sync[1] != r_key) begin
                w_key   = r_sync[1];
                w_cnt   = '0;
                w_state = (LOCK_CYCLES == 1) ? IDLE : LOCK;
            end
        end else begin
            w_cnt = r_cnt + LCW'(1);
            if (w_cnt == LCW'(LOCK_CYCLES - 1)) w_state = IDLE;
        end
    end

    assign w_rise    = w_key & ~r_key;
    assign w_fall    = ~w_key & r_key;
    assign w_at_long = r_key && (r_press == DUR_W'(LONG_CYCLES));

    // FSM state, debounced level and edge pulses
    always_ff @(posedge clk_fast) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_key   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_key   <= w_key;
            r_rise  <= w_rise;
            r_fall  <= w_fall;
        end
    end

    // press length counter, single long-press pulse and duration capture on release
    always_ff @(posedge clk_fast) begin
        if (!rst) begin
            r_press     <= '0;
            r_long      <= 1'b0;
            r_long_done <= 1'b0;
            r_dur       <= '0;
            r_dur_v     <= 1'b0;
        end else begin
            r_press     <= w_rise ? DUR_W'(1) : (w_key && r_press != DUR_MAX) ? r_press + DUR_W'(1) : r_press;
            r_long      <= w_at_long && !r_long_done;
            r_long_done <= w_rise ? 1'b0 : (r_long_done | w_at_long);
            r_dur       <= w_fall ? r_press : r_dur;
            r_dur_v     <= w_fall;
        end
    end

    assign o_key       = r_key;
    assign o_rise      = r_rise;
    assign o_fall      = r_fall;
    assign o_long      = r_long;
    assign o_dur       = r_dur;
    assign o_dur_valid = r_dur_v;
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: N_CH independent debounced key channels with press timing
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int N_CH        = N_CH_DEF,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF,
    parameter int DUR_W       = DUR_W_DEF
) (
    input  logic                  clk_fast,
    input  logic                  rst,
    input  logic [N_CH-1:0]       key_in,
    output logic [N_CH-1:0]       key_out,
    output logic [N_CH-1:0]       rise_o,
    output logic [N_CH-1:0]       fall_o,
    output logic [N_CH-1:0]       long_o,
    output logic [N_CH*DUR_W-1:0] dur_o,
    output logic [N_CH-1:0]       dur_valid_o
);
    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            key_conditioner_ch #(
                .LOCK_CYCLES(LOCK_CYCLES),
                .LONG_CYCLES(LONG_CYCLES),
                .DUR_W      (DUR_W)
            ) u_ch (
                .clk_fast   (clk_fast),
                .rst        (rst),
                .i_key      (key_in[i]),
                .o_key      (key_out[i]),
                .o_rise     (rise_o[i]),
                .o_fall     (fall_o[i]),
                .o_long     (long_o[i]),
                .o_dur      (dur_o[i*DUR_W +: DUR_W]),
                .o_dur_valid(dur_valid_o[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed and random stimulus against a timing-based reference model
module tb_key_conditioner;
    localparam int NC = 2;
    localparam int LC = 8;
    localparam int LG = 20;
    localparam int DW = 8;

    logic             clk_fast = 1'b0;
    logic             rst      = 1'b0;
    logic [NC-1:0]    key_in   = '0;
    logic [NC-1:0]    key_out, rise_o, fall_o, long_o, dur_valid_o;
    logic [NC*DW-1:0] dur_o;

    always #5 clk_fast = ~clk_fast;

    key_conditioner #(.N_CH(NC), .LOCK_CYCLES(LC), .LONG_CYCLES(LG), .DUR_W(DW)) dut (
        .clk_fast   (clk_fast),
        .rst        (rst),
        .key_in     (key_in),
        .key_out    (key_out),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .long_o     (long_o),
        .dur_o      (dur_o),
        .dur_valid_o(dur_valid_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model: key history, time of last accepted change and of last rise
    logic [NC-1:0]    m_h1 = '0, m_h2 = '0, m_key = '0;
    logic [NC-1:0]    m_rise = '0, m_fall = '0, m_long = '0, m_dv = '0;
    logic [NC*DW-1:0] m_dur = '0;
    int               last_chg[NC];
    int               rise_t[NC];

    // ch0 event log for directed checks
    int n_rise, n_fall, n_long, n_dv, t_rise, t_fall, t_long;
    logic dv_at_fall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_rise = 0; n_fall = 0; n_long = 0; n_dv = 0;
        t_rise = -1000; t_fall = -1000; t_long = -1000;
        dv_at_fall = 1'b0;
    endtask

    task automatic step(input logic [NC-1:0] k, input logic r);
        key_in = k;
        rst    = r;
        @(posedge clk_fast);
        #1;
        cyc++;
        for (int c = 0; c < NC; c++) begin
            if (!r) begin
                m_h1[c] = 1'b0; m_h2[c] = 1'b0; m_key[c] = 1'b0;
                m_rise[c] = 1'b0; m_fall[c] = 1'b0; m_long[c] = 1'b0; m_dv[c] = 1'b0;
                m_dur[c*DW +: DW] = '0;
                last_chg[c] = -1000;
            end else begin
                logic d, acc;
                int len;
                d = m_h2[c];
                m_h2[c] = m_h1[c];
                m_h1[c] = k[c];
                acc = (d != m_key[c]) && (cyc - last_chg[c] >= LC);
                m_long[c] = m_key[c] && (cyc - rise_t[c] == LG);
                m_rise[c] = acc && d;
                m_fall[c] = acc && !d;
                m_dv[c]   = m_fall[c];
                len = cyc - rise_t[c];
                if (m_fall[c]) m_dur[c*DW +: DW] = DW'((len > 255) ? 255 : len);
                if (acc) begin
                    m_key[c] = d;
                    last_chg[c] = cyc;
                    if (d) rise_t[c] = cyc;
                end
            end
        end
        chk("key_out", 32'(key_out), 32'(m_key));
        chk("rise_o", 32'(rise_o), 32'(m_rise));
        chk("fall_o", 32'(fall_o), 32'(m_fall));
        chk("long_o", 32'(long_o), 32'(m_long));
        chk("dur_valid_o", 32'(dur_valid_o), 32'(m_dv));
        chk("dur_o", 32'(dur_o), 32'(m_dur));
        if (rise_o[0]) begin n_rise++; t_rise = cyc; end
        if (fall_o[0]) begin n_fall++; t_fall = cyc; dv_at_fall = dur_valid_o[0]; end
        if (long_o[0]) begin n_long++; t_long = cyc; end
        if (dur_valid_o[0]) n_dv++;
    endtask

    initial begin
        for (int c = 0; c < NC; c++) begin
            last_chg[c] = -1000;
            rise_t[c]   = -1000;
        end
        clr();
        repeat (3) step(2'b00, 1'b0);
        chk("reset_outputs", 32'({key_out, rise_o, fall_o, long_o, dur_valid_o, dur_o}), 32'd0);
        while (cyc < 10) step(2'b00, 1'b1);
        // clean press of 30 cycles
        clr();
        for (int i = 0; i < 10 && n_rise == 0; i++) step(2'b01, 1'b1);
        chk("rise_edge", t_rise, 13);
        chk("ch1_quiet", 32'(key_out[1]), 32'd0);
        repeat (27) step(2'b01, 1'b1);
        for (int i = 0; i < 10 && n_fall == 0; i++) step(2'b00, 1'b1);
        chk("long_after_rise", t_long - t_rise, 20);
        chk("long_count", n_long, 1);
        chk("fall_after_rise", t_fall - t_rise, 30);
        chk("dv_with_fall", 32'(dv_at_fall), 32'd1);
        chk("dur_30", 32'(dur_o[DW-1:0]), 32'd30);
        repeat (20) step(2'b00, 1'b1);
        // bounce after the rise
        clr();
        step(2'b01, 1'b1);
        for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 2'b00 : 2'b01, 1'b1);
        repeat (25) step(2'b01, 1'b1);
        chk("bounce_rises", n_rise, 1);
        chk("bounce_falls", n_fall, 0);
        repeat (15) step(2'b00, 1'b1);
        // release during lockout
        clr();
        for (int i = 0; i < 10 && n_rise == 0; i++) step(2'b01, 1'b1);
        repeat (2) step(2'b01, 1'b1);
        repeat (15) step(2'b00, 1'b1);
        chk("lock_fall_delay", t_fall - t_rise, 8);
        chk("lock_fall_count", n_fall, 1);
        repeat (10) step(2'b00, 1'b1);
        // saturation
        clr();
        repeat (300) step(2'b01, 1'b1);
        repeat (15) step(2'b00, 1'b1);
        chk("sat_dur", 32'(dur_o[DW-1:0]), 32'd255);
        chk("sat_long_count", n_long, 1);
        chk("sat_dv_count", n_dv, 1);
        // reset mid-press with key still held
        clr();
        repeat (30) step(2'b01, 1'b1);
        chk("held_before_reset", 32'(key_out[0]), 32'd1);
        step(2'b01, 1'b0);
        chk("midpress_reset_outputs", 32'({key_out, rise_o, fall_o, long_o, dur_valid_o, dur_o}), 32'd0);
        begin
            int rel;
            rel = cyc;
            clr();
            for (int i = 0; i < 10 && n_rise == 0; i++) step(2'b01, 1'b1);
            chk("rise_after_reset", t_rise - rel, 3);
        end
        chk("no_fall_after_reset", n_fall, 0);
        chk("no_dv_after_reset", n_dv, 0);
        repeat (20) step(2'b01, 1'b1);
        repeat (15) step(2'b00, 1'b1);
        // random segments with occasional resets
        for (int s = 0; s < 400; s++) begin
            logic [NC-1:0] v;
            int len;
            v   = NC'($urandom_range(0, 3));
            len = $urandom_range(1, 40);
            if ($urandom_range(0, 59) == 0) step(v, 1'b0);
            repeat (len) step(v, 1'b1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
